clk_div_prog: RTL and testbench

Multi-channel, runtime-programmable clock divider with a glitch-free output selector. It supersedes the fixed /2, /4, /8, /3 divider bank. Each of NCH channels divides `clk` by its own WIDTH-bit divisor, and divisor changes take effect only at a period boundary. `dclk` switches between channels without runt pulses, and lab clock-generation logic consumes it.

---
 rtl/clk_div_prog.sv | 142 ++++++++++++++
 tb/tb_clk_div_prog.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: NCH runtime-programmable clock dividers plus a glitch-free
// selector that drives dclk from one channel at a time.
// Optional build macro: CLK_DIV_ODD_HALF_EN (adds a negedge stage per channel
// so odd divisors produce an exact 50% duty cycle).

// One divider channel: boundary-reloaded divisor, phase counter, output phase.
module clk_div_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] div,
  output logic             o_clk
);
  logic [WIDTH-1:0] div_c;   // divisor with 0/1 promoted to 2
  logic [WIDTH-1:0] n_div;   // divisor in force for the current period
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] half;    // ceil(n_div/2): cycles spent high
  logic             p;

  assign div_c = (div[WIDTH-1:1] == '0) ? WIDTH'(2) : div;
  assign half  = (n_div >> 1) + {{(WIDTH-1){1'b0}}, n_div[0]};

  // Period counter and high-phase register; divisor reloads only on the last cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      p     <= 1'b0;
      n_div <= div_c;
    end else begin
      p <= (cnt < half);
      if (cnt == n_div - 1'b1) begin
        cnt   <= '0;
        n_div <= div_c;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef CLK_DIV_ODD_HALF_EN
  logic n;

  // Half-cycle delayed copy of p; ANDing it trims the odd high phase by half a clk
  always_ff @(negedge clk) begin
    if (!rst_n) n <= 1'b0;
    else        n <= p;
  end

  assign o_clk = n_div[0] ? (p & n) : p;
`else
  assign o_clk = p;
`endif

endmodule

module clk_div_prog #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] div_i,
  input  logic [SELW-1:0]      sel,
  output logic [NCH-1:0]       o_clk,
  output logic                 dclk,
  output logic                 sel_busy,
  output logic [SELW-1:0]      cur_sel
);
  typedef enum logic [1:0] {IDLE, DROP_OLD, WAIT_NEW} sel_state_t;

  sel_state_t      state, state_nx;
  logic [SELW-1:0] sel_c;
  logic [SELW-1:0] nxt, nxt_nx, cur_nx;
  logic            gate, gate_nx;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_chan #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .div   (div_i[g*WIDTH +: WIDTH]),
      .o_clk (o_clk[g])
    );
  end

  // Out-of-range selections fall back to channel 0
  if ((1 << SELW) > NCH) begin : g_sel_clamp
    assign sel_c = (int'(sel) >= NCH) ? '0 : sel;
  end else begin : g_sel_pass
    assign sel_c = sel;
  end

  // Selector state; reset adopts the requested channel directly with the gate open
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_sel <= sel_c;
      nxt     <= sel_c;
      gate    <= 1'b1;
    end else begin
      state   <= state_nx;
      cur_sel <= cur_nx;
      nxt     <= nxt_nx;
      gate    <= gate_nx;
    end
  end

  // Close the gate while the old channel is low, reopen it while the new one is low
  always_comb begin
    state_nx = state;
    cur_nx   = cur_sel;
    nxt_nx   = nxt;
    gate_nx  = gate;
    case (state)
      IDLE: begin
        if (sel_c != cur_sel) begin
          nxt_nx   = sel_c;
          state_nx = DROP_OLD;
        end
      end
      DROP_OLD: begin
        if (!o_clk[cur_sel]) begin
          gate_nx  = 1'b0;
          state_nx = WAIT_NEW;
        end
      end
      WAIT_NEW: begin
        if (!o_clk[nxt]) begin
          cur_nx   = nxt;
          gate_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sel_busy = (state != IDLE);
  assign dclk     = gate & o_clk[cur_sel];

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized and directed bench for clk_div_prog against a period-level reference model.
module tb_clk_div_prog;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;
  localparam int VW    = NCH + 2 + SELW;
`ifdef CLK_DIV_ODD_HALF_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] div_i;
  logic [SELW-1:0]      sel;
  logic [NCH-1:0]       o_clk;
  logic                 dclk, sel_busy;
  logic [SELW-1:0]      cur_sel;

  int vectors = 0;
  int miscompares = 0;

  clk_div_prog #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .div_i(div_i), .sel(sel),
    .o_clk(o_clk), .dclk(dclk), .sel_busy(sel_busy), .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;

  // Fine-grained width monitors (time units) on channel 1 and dclk
  time t1_edge = 0, t1_hi = 0, t1_lo = 0, td_rise = 0;
  int  dclk_short = 0;
  always @(o_clk[1]) begin
    if (o_clk[1]) t1_lo <= $time - t1_edge;
    else          t1_hi <= $time - t1_edge;
    t1_edge <= $time;
  end
  always @(posedge dclk) td_rise <= $time;
  always @(negedge dclk) if ($time - td_rise < 10) dclk_short <= dclk_short + 1;

  // Reference model: each channel emits periods of ceil(N/2) high then the rest low,
  // with the next N taken from div_i on the last cycle of a period.
  int unsigned   m_t;
  int unsigned   m_start [NCH];
  int unsigned   m_n     [NCH];
  bit            m_p     [NCH];
  bit            m_pp    [NCH];
  logic [NCH-1:0] m_o;
  int            m_cur, m_tgt;
  bit            m_sw, m_drop, m_gate;

  function automatic int clampd(int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic int divk(int k);
    return int'(div_i[k*WIDTH +: WIDTH]);
  endfunction

  function automatic int selc();
    int s;
    s = int'(sel);
    return (s >= NCH) ? 0 : s;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_o, m_gate & m_o[m_cur], m_sw, SELW'(m_cur)};
  endfunction

  task automatic step();
    int unsigned off;
    if (!rst_n) begin
      m_t = 0; m_sw = 0; m_drop = 0; m_gate = 1; m_cur = selc(); m_tgt = m_cur;
      for (int k = 0; k < NCH; k++) begin
        m_n[k] = clampd(divk(k)); m_start[k] = 0; m_p[k] = 0; m_pp[k] = 0; m_o[k] = 1'b0;
      end
    end else begin
      // the switch protocol looks at each channel's level just before this edge
      if (!m_sw) begin
        if (selc() != m_cur) begin m_sw = 1; m_drop = 0; m_tgt = selc(); end
      end else if (!m_drop) begin
        if (!m_p[m_cur]) begin m_drop = 1; m_gate = 0; end
      end else if (!m_p[m_tgt]) begin
        m_cur = m_tgt; m_sw = 0; m_gate = 1;
      end
      for (int k = 0; k < NCH; k++) begin
        off = m_t - m_start[k];
        m_pp[k] = m_p[k];
        m_p[k]  = (off < (m_n[k] + 1) / 2);
        m_o[k]  = (HALF && (m_n[k] % 2 == 1)) ? (m_p[k] & m_pp[k]) : m_p[k];
        if (off == m_n[k] - 1) begin
          m_start[k] = m_t + 1;
          m_n[k] = clampd(divk(k));
        end
      end
      m_t++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    step();
    #2;
  endtask

  task automatic set_div(input int k, input int v);
    div_i[k*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic test_reset();
    rst_n = 0; sel = 0;
    set_div(3, 8); set_div(2, 4); set_div(1, 3); set_div(0, 2);
    repeat (3) tick();
    vectors++;
    if ({o_clk, dclk, sel_busy, cur_sel} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", {o_clk, dclk, sel_busy, cur_sel}, {VW{1'b0}});
    end
    rst_n = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      vectors++;
      if (o_clk[0] !== ((i % 2) == 1)) begin
        miscompares++;
        $display("FAIL reset_toggle ch0 cycle %0d: got %b want %b", i, o_clk[0], (i % 2) == 1);
      end
    end
  endtask

  task automatic test_even();
    int hi2 = 0, hi3 = 0, r2 = 0, r3 = 0;
    logic [NCH-1:0] prev = '0;
    rst_n = 0; sel = 0;
    set_div(0, 2); set_div(1, 3); set_div(2, 4); set_div(3, 8);
    tick(); rst_n = 1;
    for (int i = 0; i < 80; i++) begin
      tick();
      vectors++;
      if ({o_clk, dclk, sel_busy, cur_sel} !== exp_vec()) begin
        miscompares++;
        $display("FAIL even_model cycle %0d: got %b want %b", i, {o_clk, dclk, sel_busy, cur_sel}, exp_vec());
      end
      hi2 += int'(o_clk[2]); hi3 += int'(o_clk[3]);
      r2 += int'(o_clk[2] & ~prev[2]); r3 += int'(o_clk[3] & ~prev[3]);
      prev = o_clk;
    end
    vectors++;
    if (hi2 != 40 || r2 != 20) begin
      miscompares++;
      $display("FAIL even_n4: high %0d rises %0d, want 40 20", hi2, r2);
    end
    vectors++;
    if (hi3 != 40 || r3 != 10) begin
      miscompares++;
      $display("FAIL even_n8: high %0d rises %0d, want 40 10", hi3, r3);
    end
  endtask

  task automatic test_odd();
    int hi = 0;
    rst_n = 0; sel = 1;
    set_div(1, 3);
    tick(); rst_n = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      vectors++;
      if ({o_clk, dclk, sel_busy, cur_sel} !== exp_vec()) begin
        miscompares++;
        $display("FAIL odd_model cycle %0d: got %b want %b", i, {o_clk, dclk, sel_busy, cur_sel}, exp_vec());
      end
      hi += int'(o_clk[1]);
    end
    vectors++;
    if (hi != (HALF ? 10 : 20)) begin
      miscompares++;
      $display("FAIL odd_high_samples: got %0d want %0d", hi, HALF ? 10 : 20);
    end
    vectors++;
    if (t1_hi != (HALF ? 15 : 20) || t1_lo != (HALF ? 15 : 10)) begin
      miscompares++;
      $display("FAIL odd_widths: high %0t low %0t, want %0d %0d", t1_hi, t1_lo, HALF ? 15 : 20, HALF ? 15 : 10);
    end
  endtask

  task automatic test_div_change();
    int rises[$];
    logic prev = 1'b0;
    rst_n = 0; sel = 0;
    set_div(1, 4);
    tick(); rst_n = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) set_div(1, 6);  // channel 1 is at cnt=1 now
      vectors++;
      if ({o_clk, dclk, sel_busy, cur_sel} !== exp_vec()) begin
        miscompares++;
        $display("FAIL divchg_model cycle %0d: got %b want %b", i, {o_clk, dclk, sel_busy, cur_sel}, exp_vec());
      end
      if (o_clk[1] && !prev) rises.push_back(i);
      prev = o_clk[1];
    end
    vectors++;
    if (rises.size() < 3 || rises[1] - rises[0] != 4 || rises[2] - rises[1] != 6) begin
      miscompares++;
      $display("FAIL divchg_periods: rises %p, want [1,5,11]", rises);
    end
    set_div(1, 0);
    rises.delete();
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if ({o_clk, dclk, sel_busy, cur_sel} !== exp_vec()) begin
        miscompares++;
        $display("FAIL div0_model cycle %0d: got %b want %b", i, {o_clk, dclk, sel_busy, cur_sel}, exp_vec());
      end
      if (o_clk[1] && !prev) rises.push_back(i);
      prev = o_clk[1];
    end
    vectors++;
    if (rises.size() < 2 || rises[rises.size()-1] - rises[rises.size()-2] != 2) begin
      miscompares++;
      $display("FAIL div0_period: rises %p, want spacing 2", rises);
    end
  endtask

  task automatic test_switch();
    int n, short0;
    rst_n = 0; sel = 0;
    set_div(0, 2); set_div(3, 3);
    tick(); rst_n = 1;
    short0 = dclk_short;
    n = 0;
    do begin tick(); n++; end while (!o_clk[0] && n < 10);
    vectors++;
    if (!o_clk[0] || dclk !== 1'b1) begin
      miscompares++;
      $display("FAIL switch_pre: o_clk0 %b dclk %b, want 1 1", o_clk[0], dclk);
    end
    sel = 3;
    n = 0;
    do begin
      tick(); n++;
      vectors++;
      if ({o_clk, dclk, sel_busy, cur_sel} !== exp_vec()) begin
        miscompares++;
        $display("FAIL switch_model cycle %0d: got %b want %b", n, {o_clk, dclk, sel_busy, cur_sel}, exp_vec());
      end
    end while (sel_busy && n < 20);
    vectors++;
    if (n > 5 || cur_sel !== 2'd3) begin
      miscompares++;
      $display("FAIL switch_latency: %0d cycles cur_sel %0d, want <=5 and 3", n, cur_sel);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (dclk !== o_clk[3]) begin
        miscompares++;
        $display("FAIL switch_follow cycle %0d: dclk %b want %b", i, dclk, o_clk[3]);
      end
    end
    vectors++;
    if (dclk_short != short0) begin
      miscompares++;
      $display("FAIL switch_runt: %0d short pulses, want 0", dclk_short - short0);
    end
  endtask

  task automatic test_mid_switch();
    int n, short0;
    rst_n = 0; sel = 0;
    set_div(0, 8); set_div(1, 2); set_div(2, 4); set_div(3, 3);
    repeat (2) tick();
    rst_n = 1;
    repeat (2) tick();
    short0 = dclk_short;
    sel = 1;
    tick();
    sel = 2;
    vectors++;
    if (sel_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy: got %b want 1", sel_busy);
    end
    n = 0;
    while (sel_busy && n < 30) begin
      tick(); n++;
      vectors++;
      if ({o_clk, dclk, sel_busy, cur_sel} !== exp_vec()) begin
        miscompares++;
        $display("FAIL mid_model1 cycle %0d: got %b want %b", n, {o_clk, dclk, sel_busy, cur_sel}, exp_vec());
      end
    end
    vectors++;
    if (sel_busy !== 1'b0 || cur_sel !== 2'd1) begin
      miscompares++;
      $display("FAIL mid_first: busy %b cur_sel %0d, want 0 1", sel_busy, cur_sel);
    end
    tick();
    vectors++;
    if (sel_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_second_start: busy %b want 1", sel_busy);
    end
    n = 0;
    while (sel_busy && n < 30) begin
      tick(); n++;
      vectors++;
      if ({o_clk, dclk, sel_busy, cur_sel} !== exp_vec()) begin
        miscompares++;
        $display("FAIL mid_model2 cycle %0d: got %b want %b", n, {o_clk, dclk, sel_busy, cur_sel}, exp_vec());
      end
    end
    vectors++;
    if (sel_busy !== 1'b0 || cur_sel !== 2'd2 || dclk_short != short0) begin
      miscompares++;
      $display("FAIL mid_second: busy %b cur_sel %0d short %0d, want 0 2 0", sel_busy, cur_sel, dclk_short - short0);
    end
    sel = 3;
    n = 0;
    do begin tick(); n++; end while (!(m_sw && m_drop) && n < 30);
    vectors++;
    if (!(m_sw && m_drop) || sel_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_wait_new: busy %b, want 1 within 30 cycles", sel_busy);
    end
    rst_n = 0;
    tick();
    vectors++;
    if ({o_clk, dclk, sel_busy} !== '0 || cur_sel !== 2'd3) begin
      miscompares++;
      $display("FAIL mid_reset: outs %b cur_sel %0d, want 0 3", {o_clk, dclk, sel_busy}, cur_sel);
    end
    rst_n = 1;
  endtask

  task automatic test_random();
    rst_n = 0; sel = 0;
    for (int k = 0; k < NCH; k++) set_div(k, $urandom_range(0, 9));
    tick(); rst_n = 1;
    for (int i = 0; i < 600; i++) begin
      tick();
      vectors++;
      if ({o_clk, dclk, sel_busy, cur_sel} !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_model cycle %0d: got %b want %b", i, {o_clk, dclk, sel_busy, cur_sel}, exp_vec());
      end
      if ($urandom_range(0, 7) == 0) set_div($urandom_range(0, NCH-1), $urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) sel = SELW'($urandom_range(0, NCH-1));
      rst_n = ($urandom_range(0, 99) != 0);
    end
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; sel = 0; div_i = '0;
    test_reset();
    test_even();
    test_odd();
    test_div_change();
    test_switch();
    test_mid_switch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
